// File: rtl/risc_ctrl_seq.sv
// risc_ctrl_seq: self-sequencing 8-phase RISC control unit with latched HALT/resume.
// Optional memory-ready stall in P1/P5 is compiled in with `define RISC_CTRL_STALL_EN.
module risc_ctrl_seq #(
  parameter int unsigned      OPC_W  = 3,
  parameter logic [OPC_W-1:0] OP_HLT = OPC_W'(0),
  parameter logic [OPC_W-1:0] OP_SKZ = OPC_W'(1),
  parameter logic [OPC_W-1:0] OP_ADD = OPC_W'(2),
  parameter logic [OPC_W-1:0] OP_AND = OPC_W'(3),
  parameter logic [OPC_W-1:0] OP_XOR = OPC_W'(4),
  parameter logic [OPC_W-1:0] OP_LDA = OPC_W'(5),
  parameter logic [OPC_W-1:0] OP_STO = OPC_W'(6),
  parameter logic [OPC_W-1:0] OP_JMP = OPC_W'(7)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_rdy,
  input  logic             resume,
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
  output logic             halted,
  output logic [2:0]       phase
);

  localparam logic [3:0] S_P0   = 4'd0;
  localparam logic [3:0] S_P1   = 4'd1;
  localparam logic [3:0] S_P2   = 4'd2;
  localparam logic [3:0] S_P3   = 4'd3;
  localparam logic [3:0] S_P4   = 4'd4;
  localparam logic [3:0] S_P5   = 4'd5;
  localparam logic [3:0] S_P6   = 4'd6;
  localparam logic [3:0] S_P7   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0] state_q, state_d;
  logic       is_hlt, is_skz, is_sto, is_jmp, is_alu;
  logic       p1_go, p5_go;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

`ifdef RISC_CTRL_STALL_EN
  // Only instruction fetch and ALU operand fetch wait on memory.
  assign p1_go = mem_rdy;
  assign p5_go = mem_rdy || !is_alu;
`else
  logic stall_unused;
  assign stall_unused = mem_rdy;
  assign p1_go = 1'b1;
  assign p5_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_P0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_P0:    state_d = S_P1;
      S_P1:    if (p1_go) state_d = S_P2;
      S_P2:    state_d = S_P3;
      S_P3:    state_d = S_P4;
      S_P4:    state_d = is_hlt ? S_HALT : S_P5;
      S_P5:    if (p5_go) state_d = S_P6;
      S_P6:    state_d = S_P7;
      S_P7:    state_d = S_P0;
      S_HALT:  if (resume) state_d = S_P0;
      default: state_d = S_P0;
    endcase
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    halted = 1'b0;
    phase  = '0;
    if (rst) begin
      if (state_q != S_HALT) phase = state_q[2:0];
      case (state_q)
        S_P0: sel = 1'b1;
        S_P1: begin sel = 1'b1; rd = 1'b1; end
        S_P2, S_P3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        S_P4: inc_pc = 1'b1;
        S_P5: rd = is_alu;
        S_P6: begin
          rd     = is_alu;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        S_P7: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Table-driven bench for risc_ctrl_seq (OPC_W=4) with a per-cycle expected-output scoreboard.
module tb_risc_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero, mem_rdy, resume;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halted;
  logic [2:0] phase;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [11:0] exp_q[$];

  risc_ctrl_seq #(.OPC_W(4)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
    .resume(resume), .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac), .data_e(data_e),
    .halted(halted), .phase(phase)
  );

  always #5 clk = ~clk;

  // Strobe byte order: {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e}
  typedef struct {
    logic [3:0] op;
    logic       z;
    logic [7:0] e5, e6, e7;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input logic [7:0] es, input logic [2:0] ep, input logic eh, input string nm);
    logic [11:0] got, e;
    exp_q.push_back({es, ep, eh});
    @(negedge clk);
    got = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, phase, halted};
    e = exp_q.pop_front();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got strobes=%h phase=%0d halted=%b, expected strobes=%h phase=%0d halted=%b",
               nm, got[11:4], got[3:1], got[0], e[11:4], e[3:1], e[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_phases(input string nm);
    chk(8'h80, 3'd0, 1'b0, {nm, "_p0"});
    chk(8'hC0, 3'd1, 1'b0, {nm, "_p1"});
    chk(8'hD0, 3'd2, 1'b0, {nm, "_p2"});
    chk(8'hD0, 3'd3, 1'b0, {nm, "_p3"});
    chk(8'h08, 3'd4, 1'b0, {nm, "_p4"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'd2, 1'b1, 8'h40, 8'h40, 8'h42};  // ADD
    vecs[1] = '{4'd3, 1'b0, 8'h40, 8'h40, 8'h42};  // AND
    vecs[2] = '{4'd4, 1'b1, 8'h40, 8'h40, 8'h42};  // XOR
    vecs[3] = '{4'd5, 1'b0, 8'h40, 8'h40, 8'h42};  // LDA
    vecs[4] = '{4'd1, 1'b1, 8'h00, 8'h08, 8'h00};  // SKZ taken
    vecs[5] = '{4'd1, 1'b0, 8'h00, 8'h00, 8'h00};  // SKZ not taken
    vecs[6] = '{4'd6, 1'b1, 8'h00, 8'h01, 8'h21};  // STO
    vecs[7] = '{4'd7, 1'b0, 8'h00, 8'h04, 8'h04};  // JMP
    vecs[8] = '{4'hA, 1'b1, 8'h00, 8'h00, 8'h00};  // NOP aliasing ADD in low bits
    vecs[9] = '{4'h9, 1'b1, 8'h00, 8'h00, 8'h00};  // NOP aliasing SKZ in low bits

    rst = 1'b0; opcode = 4'd2; zero = 1'b0; mem_rdy = 1'b1; resume = 1'b1;
    @(posedge clk); #1;
    chk(8'h00, 3'd0, 1'b0, "reset_a");
    chk(8'h00, 3'd0, 1'b0, "reset_b");
    rst = 1'b1; resume = 1'b0;

    for (int i = 0; i < 10; i++) begin
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      fetch_phases($sformatf("v%0d", i));
      chk(vecs[i].e5, 3'd5, 1'b0, $sformatf("v%0d_p5", i));
      chk(vecs[i].e6, 3'd6, 1'b0, $sformatf("v%0d_p6", i));
      chk(vecs[i].e7, 3'd7, 1'b0, $sformatf("v%0d_p7", i));
    end

    // HLT: park in HALT for 10 cycles, then resume.
    opcode = 4'd0; zero = 1'b0;
    fetch_phases("hlt");
    for (int c = 0; c < 10; c++) chk(8'h00, 3'd0, 1'b1, $sformatf("halt_%0d", c));
    resume = 1'b1;
    chk(8'h00, 3'd0, 1'b1, "halt_resume");
    resume = 1'b0;
    opcode = 4'd2;
    fetch_phases("post_halt");
    chk(8'h40, 3'd5, 1'b0, "post_halt_p5");
    chk(8'h40, 3'd6, 1'b0, "post_halt_p6");
    chk(8'h42, 3'd7, 1'b0, "post_halt_p7");

    // Reset in HALT overrides a simultaneous resume.
    opcode = 4'd0;
    fetch_phases("hlt2");
    chk(8'h00, 3'd0, 1'b1, "halt2");
    rst = 1'b0; resume = 1'b1;
    chk(8'h00, 3'd0, 1'b0, "halt2_rst");
    rst = 1'b1; resume = 1'b0;
    opcode = 4'd7;

    // JMP aborted by reset in P6, then 0xA runs as NOP.
    fetch_phases("jmp_rst");
    chk(8'h00, 3'd5, 1'b0, "jmp_rst_p5");
    rst = 1'b0;
    chk(8'h00, 3'd0, 1'b0, "jmp_rst_p6_in_reset");
    rst = 1'b1; opcode = 4'hA;
    fetch_phases("nop_after_rst");
    chk(8'h00, 3'd5, 1'b0, "nop_after_rst_p5");
    chk(8'h00, 3'd6, 1'b0, "nop_after_rst_p6");
    chk(8'h00, 3'd7, 1'b0, "nop_after_rst_p7");

    // LDA with mem_rdy low for 3 cycles in P1 and 2 cycles in P5.
    opcode = 4'd5;
    chk(8'h80, 3'd0, 1'b0, "lda_st_p0");
    mem_rdy = 1'b0;
`ifdef RISC_CTRL_STALL_EN
    for (int c = 0; c < 3; c++) chk(8'hC0, 3'd1, 1'b0, $sformatf("lda_st_p1_hold%0d", c));
    mem_rdy = 1'b1;
    chk(8'hC0, 3'd1, 1'b0, "lda_st_p1_go");
    chk(8'hD0, 3'd2, 1'b0, "lda_st_p2");
    chk(8'hD0, 3'd3, 1'b0, "lda_st_p3");
    chk(8'h08, 3'd4, 1'b0, "lda_st_p4");
    mem_rdy = 1'b0;
    for (int c = 0; c < 2; c++) chk(8'h40, 3'd5, 1'b0, $sformatf("lda_st_p5_hold%0d", c));
    mem_rdy = 1'b1;
    chk(8'h40, 3'd5, 1'b0, "lda_st_p5_go");
`else
    chk(8'hC0, 3'd1, 1'b0, "lda_st_p1");
    chk(8'hD0, 3'd2, 1'b0, "lda_st_p2");
    chk(8'hD0, 3'd3, 1'b0, "lda_st_p3");
    chk(8'h08, 3'd4, 1'b0, "lda_st_p4");
    chk(8'h40, 3'd5, 1'b0, "lda_st_p5");
    mem_rdy = 1'b1;
`endif
    chk(8'h40, 3'd6, 1'b0, "lda_st_p6");
    chk(8'h42, 3'd7, 1'b0, "lda_st_p7");
    chk(8'h80, 3'd0, 1'b0, "lda_st_next_p0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_ctrl_seq.md
# risc_ctrl_seq

Self-sequencing control unit for the RISC CPU that replaces the externally phased two-clock decoder. It holds its own 8-phase instruction cycle, decodes a parametrised opcode, and drives the address mux, memory, IR, PC and accumulator strobes. It adds three things the old decoder lacked: a latched halt state with resume, an optional memory-ready stall, and configurable opcode width and encodings. It sits between the IR/ALU zero flag and the datapath load enables.

## Interface
- OPC_W, 3, opcode width in bits (≥3); unlisted codes decode as NOP
- OP_HLT, 0, halt opcode
- OP_SKZ, 1, skip-if-zero opcode
- OP_ADD, 2, ALU add opcode
- OP_AND, 3, ALU and opcode
- OP_XOR, 4, ALU xor opcode
- OP_LDA, 5, load-accumulator opcode
- OP_STO, 6, store opcode
- OP_JMP, 7, jump opcode
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, synchronous, active-low
- opcode  in  OPC_W  current IR opcode field
- zero  in  1  accumulator-zero flag
- mem_rdy  in  1  memory ready; used only when the stall feature is compiled in
- resume  in  1  leaves HALT
- sel  out  1  address mux: 1 = PC, 0 = IR operand
- rd  out  1  memory read
- wr  out  1  memory write
- ld_ir  out  1  IR load enable
- inc_pc  out  1  PC increment
- ld_pc  out  1  PC load (jump)
- ld_ac  out  1  accumulator load
- data_e  out  1  data bus drive enable (store)
- halted  out  1  high in the HALT state
- phase  out  3  current phase (debug); 0 in HALT

## Operation
- States: P0..P7 (instruction cycle) and HALT. Without stalls, P(n) goes to P(n+1) and P7 goes to P0.
- ALUOP is any of ADD/AND/XOR/LDA. Decode uses a full OPC_W compare.
- Phase outputs:
  - P0 INST_ADDR: sel.
  - P1 INST_FETCH: sel, rd.
  - P2 INST_LOAD: sel, rd, ld_ir.
  - P3 IDLE: sel, rd, ld_ir.
  - P4 OP_ADDR: inc_pc. If HLT: next state is HALT instead of P5.
  - P5 OP_FETCH: rd if ALUOP.
  - P6 ALU_OP:
    - rd if ALUOP
    - inc_pc if SKZ and zero
    - ld_pc if JMP
    - data_e if STO
  - P7 STORE:
    - rd and ld_ac if ALUOP
    - ld_pc if JMP
    - wr and data_e if STO
- NOP opcodes only advance phases. Only P0–P4 outputs are asserted for them.
- HALT: all strobes are 0 and halted=1. resume=1 at an edge moves to P0. The PC was already incremented in P4, so execution continues at the instruction after HLT.
- Reset: while rst=0, every output is forced to 0. The state loads P0 at the edge.
- Reset mid-instruction or in HALT aborts unconditionally.
- rst=0 has priority over resume and mem_rdy.

## Timing
- All strobes are combinational from the registered state, opcode and zero. They are valid within the cycle of their phase.
- One instruction takes 8 cycles with no stalls.
- HLT reaches HALT 5 cycles after P0. Leaving HALT takes 1 cycle after resume is sampled.
- zero is sampled only in P6. opcode must be stable from P4 through P7.
- The IR is written in P2 and P3. opcode is don't-care during P0–P3.

## Configuration
- RISC_CTRL_STALL_EN defined:
  - In P1, and in P5 when ALUOP, the state holds while mem_rdy=0. All outputs hold for every stall cycle. The phase advances on the first edge with mem_rdy=1.
  - No other phase stalls.
  - A stall of N cycles lengthens the instruction to 8+N.
- Undefined: mem_rdy is ignored. Timing is the fixed 8-cycle instruction.

## Test plan
- ADD (opcode 2), mem_rdy=1 → rd in P1–P3 and P5–P7, ld_ir in P2–P3, inc_pc in P4 only, ld_ac in P7. Next P0 is 8 cycles after the first.
- SKZ with zero=1, then zero=0 → inc_pc asserted in P4 and P6 for the first; in P4 only for the second. No rd, wr or ld_ac.
- STO then JMP → STO: data_e in P6–P7, wr in P7 only. JMP: ld_pc in P6–P7, wr never asserted.
- HLT, hold resume=0 for 10 cycles, then pulse resume → halted=1 and phase=0 for all 10 cycles. P0 is entered the cycle after resume. inc_pc was asserted in P4.
- With RISC_CTRL_STALL_EN, LDA, mem_rdy=0 for 3 cycles in P1 and 2 in P5 → phase holds at 1 and at 5. The instruction takes 13 cycles.
- rst=0 during P6 of JMP, OPC_W=4 with opcode 4'hA → outputs go 0 immediately and the state is P0 after the edge. Opcode 0xA runs as a NOP, with strobes in P0–P4 only.
